// File: rtl/derounds_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then one inverse round per clock,
// walking the key schedule backwards in step with the rounds.
module derounds_iter (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic [127:0] i_din,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_dout
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    ARK   = 3'd2,
    ROUND = 3'd3,
    LAST  = 3'd4
  } state_t;

  // Byte 0 of each table sits in the top bits.
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] ISBOX = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] x);
    return ISBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select x, 2x, 4x, 8x (covers 09/0b/0d/0e).
  function automatic logic [7:0] gmc(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step: recover the older words first, p3 feeds the SubWord term.
  function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = isb(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmc(a0, 4'he) ^ gmc(a1, 4'hb) ^ gmc(a2, 4'hd) ^ gmc(a3, 4'h9);
      o[119 - 32*c -: 8] = gmc(a0, 4'h9) ^ gmc(a1, 4'he) ^ gmc(a2, 4'hb) ^ gmc(a3, 4'hd);
      o[111 - 32*c -: 8] = gmc(a0, 4'hd) ^ gmc(a1, 4'h9) ^ gmc(a2, 4'he) ^ gmc(a3, 4'hb);
      o[103 - 32*c -: 8] = gmc(a0, 4'hb) ^ gmc(a1, 4'hd) ^ gmc(a2, 4'h9) ^ gmc(a3, 4'he);
    end
    return o;
  endfunction

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_cnt, r_round;
  logic [127:0]   r_ct, r_st, r_rk, r_dout;
  logic           r_done;
  logic [3:0]     w_inv_idx;
  logic [127:0]   w_rk_fwd, w_rk_inv, w_ark;

  // ARK steps rk10 -> rk9 with the last rcon; ROUND r steps rk_r -> rk_(r-1).
  assign w_inv_idx = (r_state == ARK) ? 4'd10 : r_round;
  assign w_rk_fwd  = key_next(r_rk, rcon(r_cnt));
  assign w_rk_inv  = key_prev(r_rk, rcon(w_inv_idx));
  assign w_ark     = inv_sr_sb(r_st) ^ r_rk;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = KEXP;
      KEXP:    if (r_cnt == 4'd10) w_state_nxt = ARK;
      ARK:     w_state_nxt = ROUND;
      ROUND:   if (r_round == 4'd1) w_state_nxt = LAST;
      LAST:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_round <= '0;
      r_ct    <= '0;
      r_st    <= '0;
      r_rk    <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_ct  <= i_din;
          r_rk  <= i_key;
          r_cnt <= 4'd1;
        end
        KEXP: begin
          r_rk  <= w_rk_fwd;
          r_cnt <= r_cnt + 4'd1;
        end
        ARK: begin
          r_st    <= r_ct ^ r_rk;
          r_rk    <= w_rk_inv;
          r_round <= 4'd9;
        end
        ROUND: begin
          r_st    <= inv_mix(w_ark);
          r_rk    <= w_rk_inv;
          r_round <= r_round - 4'd1;
        end
        LAST: begin
          r_dout <= w_ark;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_dout = r_dout;
endmodule

// File: tb/tb_derounds_iter.sv
// Bench for derounds_iter: FIPS vectors, timing corners and a random round trip through
// a reference encryptor built from a computed S-box.
module tb_derounds_iter;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] key = '0, din = '0;
  logic         busy, done;
  logic [127:0] dout;

  derounds_iter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_key(key), .i_din(din),
    .o_busy(busy), .o_done(done), .o_dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] key; logic [127:0] din; logic [127:0] exp; } vec_t;
  typedef struct { logic [127:0] key; logic [127:0] exp; int acc; } sb_t;

  sb_t        q[$];
  int         n_chk = 0, n_fail = 0, cyc = 0, last_done = -1;
  logic [7:0] sbx [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic void init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] s, u;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]], sbx[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      u = '0;
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          u[127 - 8*(4*c + row) -: 8] = sbx[s[127 - 8*(4*((c + row) % 4) + row) -: 8]];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = u[127 - 32*c -: 8]; a1 = u[119 - 32*c -: 8];
          a2 = u[111 - 32*c -: 8]; a3 = u[103 - 32*c -: 8];
          u[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          u[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          u[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          u[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      s = u ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every done pops one expectation; rk must be back at the key during LAST.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 128'd1, 128'd0);
      else begin
        e = q.pop_front();
        chk("dout", dout, e.exp);
        chk("latency", 128'(cyc - e.acc), 128'd21);
      end
      last_done = cyc;
    end
    if (rst_n && dut.r_state == 3'd4 && q.size() != 0) chk("rk0_eq_key", dut.r_rk, q[0].key);
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic run_op(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e);
    int n;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 128'd1, 128'd0);
    start = 1'b1; key = k; din = d;
    @(negedge clk);
    q.push_back('{key: k, exp: e, acc: cyc});
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) begin chk("drain_timeout", 128'd1, 128'd0); q.delete(); end
    @(negedge clk);
  endtask

  initial begin
    vec_t         tv [6];
    int           n, d1;
    logic [127:0] k, p;
    init_sbox();
    tv[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
              din: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              exp: 128'h00112233445566778899aabbccddeeff};
    tv[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
              din: 128'h3925841d02dc09fbdc118597196a0b32,
              exp: 128'h3243f6a8885a308d313198a2e0370734};
    for (int i = 2; i < 6; i++) begin
      k = rnd128(); p = rnd128();
      tv[i] = '{key: k, din: aes_enc(k, p), exp: p};
    end

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_dout", dout, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_op(tv[i].key, tv[i].din, tv[i].exp);
    drain();

    run_op(tv[1].key, tv[1].din, tv[1].exp);
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk("busy_cycles", 128'(n), 128'd21);
    drain();

    // start held high across two operations; inputs swapped while the first is in flight
    start = 1'b1; key = tv[0].key; din = tv[0].din;
    @(negedge clk);
    q.push_back('{key: tv[0].key, exp: tv[0].exp, acc: cyc});
    key = tv[1].key; din = tv[1].din;
    repeat (21) @(negedge clk);
    @(negedge clk);
    q.push_back('{key: tv[1].key, exp: tv[1].exp, acc: cyc});
    d1 = last_done;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("dout_held", dout, tv[0].exp);
    drain();
    chk("done_period", 128'(last_done - d1), 128'd22);

    run_op(tv[0].key, tv[0].din, tv[0].exp);
    repeat (4) @(negedge clk);
    start = 1'b1; din = rnd128(); key = rnd128();
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (25) @(negedge clk);

    run_op(tv[1].key, tv[1].din, tv[1].exp);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_dout", dout, 128'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_op(tv[0].key, tv[0].din, tv[0].exp);
    drain();

    for (int i = 0; i < 1000; i++) begin
      k = rnd128(); p = rnd128();
      run_op(k, aes_enc(k, p), p);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
